// File: rtl/rb_pkg.sv
// Shared definitions for the rb_window_stream reuse buffer.
// Contents: frame FSM state enum, a width helper for counters and
// pointers, and the slot-to-bank steering helper used by the top.
package rb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } rb_state_e;

  // Slot 0 is the oldest stored row; slot K-2 the newest stored row.
  localparam int unsigned OLDEST_SLOT = 0;

  // Bits needed to index n items; never less than one bit.
  function automatic int unsigned rb_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bank that feeds window slot j when ptr names the oldest row's bank.
  function automatic int unsigned slot_bank(input int unsigned ptr,
                                            input int unsigned j,
                                            input int unsigned nbanks);
    return (ptr + j) % nbanks;
  endfunction

endpackage

// File: rtl/rb_line_mem.sv
// K-1 line banks, each DEPTH words deep, read-first.
// One bank is written per enabled cycle (i_wr_bank); every bank is read
// at the common address i_addr and the old contents are registered out.
// Ports:
//   clk        clock
//   i_en       access enable (one accepted pixel)
//   i_wr_bank  bank receiving i_wr_data
//   i_addr     common read/write address (pixel column)
//   i_wr_data  pixel to store
//   o_rd_data  registered read data, one word per bank
module rb_line_mem #(
  parameter int unsigned PW    = 8,
  parameter int unsigned NB    = 2,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned SW    = 1
) (
  input  logic                   clk,
  input  logic                   i_en,
  input  logic [SW-1:0]          i_wr_bank,
  input  logic [AW-1:0]          i_addr,
  input  logic [PW-1:0]          i_wr_data,
  output logic [NB-1:0][PW-1:0]  o_rd_data
);

  for (genvar b = 0; b < NB; b++) begin : g_bank
    // NOTE: the storage array has no reset; that keeps it mappable to
    // block RAM, and priming overwrites every word before it is read.
    logic [PW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_rd;

    // NOTE: sequential state uses non-blocking assignments so the read
    // below sees the pre-write contents (read-first) and ordering between
    // always blocks cannot change the result.
    always_ff @(posedge clk) begin
      if (i_en) begin
        r_rd <= r_mem[i_addr];
        if (i_wr_bank == SW'(b)) begin
          r_mem[i_addr] <= i_wr_data;
        end
      end
    end

    assign o_rd_data[b] = r_rd;
  end

endmodule

// File: rtl/rb_window_stream.sv
// Raster pixel stream to K-pixel vertical window columns.
// K-1 line banks rotate: ptr names the bank holding the oldest row and
// advances every row. Each accepted pixel from row K-1 onward yields one
// column {newest pixel, slot K-2, ..., slot 0} tagged with its (x, y).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   i_start        begin a frame from IDLE or DONE
//   i_in_valid / o_in_ready / i_in_pixel     input stream
//   o_out_valid / i_out_ready / o_out_col    output column stream
//   o_out_x, o_out_y   column index, row of the newest pixel
//   o_busy         RUN or DRAIN
//   o_complete     frame finished (DONE)
module rb_window_stream
  import rb_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned K           = 3,
  parameter int unsigned IMG_W       = 64,
  parameter int unsigned IMG_H       = 64,
  localparam int unsigned X_W        = rb_width(IMG_W),
  localparam int unsigned Y_W        = rb_width(IMG_H)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_start,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  input  logic [PIXEL_WIDTH-1:0]   i_in_pixel,
  output logic                     o_out_valid,
  input  logic                     i_out_ready,
  output logic [K*PIXEL_WIDTH-1:0] o_out_col,
  output logic [X_W-1:0]           o_out_x,
  output logic [Y_W-1:0]           o_out_y,
  output logic                     o_busy,
  output logic                     o_complete
);

  localparam int unsigned NB  = K - 1;
  localparam int unsigned P_W = rb_width(NB);

  rb_state_e r_state, w_state_nxt;

  logic [X_W-1:0] r_x;
  logic [Y_W-1:0] r_y;
  logic [P_W-1:0] r_ptr;

  // Stage 1: aligned with the bank read data.
  logic                   r_s1_valid;
  logic [PIXEL_WIDTH-1:0] r_s1_pix;
  logic [X_W-1:0]         r_s1_x;
  logic [Y_W-1:0]         r_s1_y;
  logic [P_W-1:0]         r_s1_ptr;

  // Stage 2: output register.
  logic                     r_out_valid;
  logic [K*PIXEL_WIDTH-1:0] r_out_col;
  logic [X_W-1:0]           r_out_x;
  logic [Y_W-1:0]           r_out_y;

  logic [NB-1:0][PIXEL_WIDTH-1:0] w_rd;
  logic [K*PIXEL_WIDTH-1:0]       w_col;
  logic w_adv, w_accept, w_x_last, w_last, w_primed, w_start_frame;

  // The pipeline moves only when the output register can take new data;
  // input acceptance uses the same condition, so stage 1 never overflows.
  assign w_adv         = !r_out_valid || i_out_ready;
  assign o_in_ready    = (r_state == ST_RUN) && w_adv;
  assign w_accept      = i_in_valid && o_in_ready;
  assign w_x_last      = (r_x == X_W'(IMG_W - 1));
  assign w_last        = w_accept && w_x_last && (r_y == Y_W'(IMG_H - 1));
  assign w_primed      = (r_y >= Y_W'(K - 1));
  assign w_start_frame = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && i_start;

  rb_line_mem #(
    .PW    (PIXEL_WIDTH),
    .NB    (NB),
    .DEPTH (IMG_W),
    .AW    (X_W),
    .SW    (P_W)
  ) u_line_mem (
    .clk       (clk),
    .i_en      (w_accept),
    .i_wr_bank (r_ptr),
    .i_addr    (r_x),
    .i_wr_data (i_in_pixel),
    .o_rd_data (w_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first, so every path assigns and no latch is inferred.
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_start) w_state_nxt = ST_RUN;
      ST_RUN:           if (w_last)  w_state_nxt = ST_DRAIN;
      ST_DRAIN:         if (!r_s1_valid && w_adv) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_start_frame) begin
      r_x   <= '0;
      r_y   <= '0;
      r_ptr <= '0;
    end else if (w_accept) begin
      if (w_x_last) begin
        r_x   <= '0;
        r_y   <= r_y + 1'b1;
        r_ptr <= (r_ptr == P_W'(NB - 1)) ? '0 : r_ptr + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  // Steering: slot j comes from bank (ptr + j) mod (K-1).
  always_comb begin
    logic [P_W-1:0] v_sel;
    v_sel = '0;
    w_col = '0;
    w_col[K*PIXEL_WIDTH-1 -: PIXEL_WIDTH] = r_s1_pix;
    for (int unsigned j = OLDEST_SLOT; j < NB; j++) begin
      v_sel = P_W'(slot_bank(32'(r_s1_ptr), j, NB));
      w_col[j*PIXEL_WIDTH +: PIXEL_WIDTH] = w_rd[v_sel];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_pix    <= '0;
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_col   <= '0;
      r_out_x     <= '0;
      r_out_y     <= '0;
    end else if (w_adv) begin
      // Priming rows fill the banks but never reach the output.
      r_s1_valid <= w_accept && w_primed;
      if (w_accept) begin
        r_s1_pix <= i_in_pixel;
        r_s1_x   <= r_x;
        r_s1_y   <= r_y;
        r_s1_ptr <= r_ptr;
      end
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_col <= w_col;
        r_out_x   <= r_s1_x;
        r_out_y   <= r_s1_y;
      end
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_col   = r_out_col;
  assign o_out_x     = r_out_x;
  assign o_out_y     = r_out_y;
  assign o_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_complete  = (r_state == ST_DONE);

endmodule

// File: tb/tb_rb_window_stream.sv
module tb_rb_window_stream;

  localparam int PW = 8;
  localparam int K  = 3;
  localparam int W  = 4;
  localparam int H  = 6;
  localparam int XW = 2;
  localparam int YW = 3;
  localparam int CW = K * PW;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [PW-1:0] i_in_pixel = '0;
  logic          o_out_valid;
  logic          i_out_ready = 1'b1;
  logic [CW-1:0] o_out_col;
  logic [XW-1:0] o_out_x;
  logic [YW-1:0] o_out_y;
  logic          o_busy;
  logic          o_complete;

  rb_window_stream #(
    .PIXEL_WIDTH (PW),
    .K           (K),
    .IMG_W       (W),
    .IMG_H       (H)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_pixel  (i_in_pixel),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_col   (o_out_col),
    .o_out_x     (o_out_x),
    .o_out_y     (o_out_y),
    .o_busy      (o_busy),
    .o_complete  (o_complete)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CW-1:0] col;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } exp_t;

  logic [PW-1:0] img [H][W];
  exp_t          exp_q [$];
  int            total = 0;
  int            bad   = 0;

  // Frame content: the y*16+x pattern or random pixels.
  task automatic fill_image(input bit pattern);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        img[y][x] = pattern ? PW'(y * 16 + x) : PW'($urandom);
  endtask

  // Reference: every window column of the frame in raster order, newest row on top.
  task automatic build_expected();
    exp_t e;
    exp_q.delete();
    for (int y = K - 1; y < H; y++)
      for (int x = 0; x < W; x++) begin
        e.col = '0;
        for (int r = 0; r < K; r++) e.col[r*PW +: PW] = img[y-(K-1)+r][x];
        e.x = XW'(x);
        e.y = YW'(y);
        exp_q.push_back(e);
      end
  endtask

  task automatic start_frame();
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    total++;
    if (o_busy !== 1'b1 || o_complete !== 1'b0) begin
      $display("FAIL start busy=%b complete=%b want busy=1 complete=0", o_busy, o_complete);
      bad++;
    end
  endtask

  // mode 0: full rate, 1: random gaps/backpressure, 2: 3-cycle stall at (1,3),
  // 3: random plus start pulses while busy. stop_after >= 0 returns once that
  // many pixels are accepted (the acceptance edge is the next posedge).
  task automatic run_frame(input int mode, input bit pattern, input int stop_after);
    int cyc, n_in, n_out, last_hs, first_ov, ninth, stall_left;
    bit stalled_done;
    exp_t e;
    cyc = 0; n_in = 0; n_out = 0; last_hs = -10; first_ov = -1; ninth = -1;
    stall_left = 0; stalled_done = 0;
    build_expected();
    start_frame();
    while (1) begin
      @(negedge clk);
      cyc++;
      if (o_complete) break;
      if (cyc > BUDGET) begin
        total++; bad++;
        $display("FAIL timeout frame mode=%0d outputs=%0d want %0d", mode, n_out, W*(H-K+1));
        break;
      end
      if (o_out_valid && first_ov < 0) first_ov = cyc;
      i_in_valid = (n_in < W*H) && ((mode == 1 || mode == 3) ? ($urandom_range(3) != 0) : 1'b1);
      i_in_pixel = (n_in < W*H) ? img[n_in / W][n_in % W] : '0;
      if (mode == 1 || mode == 3) i_out_ready = ($urandom_range(2) != 0);
      else if (mode == 2) begin
        if (!stalled_done && o_out_valid && o_out_x == 2'd1 && o_out_y == 3'd3) begin
          stalled_done = 1; stall_left = 3;
        end
        i_out_ready = (stall_left == 0);
      end else i_out_ready = 1'b1;
      i_start = (mode == 3) && o_busy && ($urandom_range(2) == 0);
      #1;
      if (stall_left > 0) begin
        total++;
        if (o_out_col !== 24'h312111 || o_in_ready !== 1'b0 || o_out_valid !== 1'b1) begin
          $display("FAIL stall_hold col=%h in_ready=%b valid=%b want col=312111 in_ready=0 valid=1",
                   o_out_col, o_in_ready, o_out_valid);
          bad++;
        end
        stall_left--;
      end
      if (i_in_valid && o_in_ready) begin
        n_in++;
        if (n_in == 9) ninth = cyc;
      end
      if (o_out_valid && i_out_ready) begin
        total++;
        last_hs = cyc;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_output col=%h x=%0d y=%0d want none", o_out_col, o_out_x, o_out_y);
          bad++;
        end else begin
          e = exp_q.pop_front();
          if (o_out_col !== e.col || o_out_x !== e.x || o_out_y !== e.y) begin
            $display("FAIL out[%0d] col=%h x=%0d y=%0d want col=%h x=%0d y=%0d",
                     n_out, o_out_col, o_out_x, o_out_y, e.col, e.x, e.y);
            bad++;
          end
        end
        if (pattern && o_out_x == 2'd2 && o_out_y == 3'd5) begin
          total++;
          if (o_out_col !== 24'h524232) begin
            $display("FAIL rotation col=%h want 524232", o_out_col);
            bad++;
          end
        end
        n_out++;
      end
      if (stop_after >= 0 && n_in == stop_after) return;
    end
    i_start = 1'b0;
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    total++;
    if (exp_q.size() != 0 || n_out != W*(H-K+1)) begin
      $display("FAIL output_count got=%0d want=%0d", n_out, W*(H-K+1));
      bad++;
    end
    total++;
    if (cyc != last_hs + 1) begin
      $display("FAIL complete_timing seen_cycle=%0d want=%0d", cyc, last_hs + 1);
      bad++;
    end
    if (mode == 0) begin
      total++;
      if (first_ov != ninth + 2) begin
        $display("FAIL first_latency out_valid_cycle=%0d want=%0d", first_ov, ninth + 2);
        bad++;
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    total++;
    if (o_in_ready !== 1'b0 || o_out_valid !== 1'b0 || o_out_col !== '0 || o_out_x !== '0 ||
        o_out_y !== '0 || o_busy !== 1'b0 || o_complete !== 1'b0) begin
      $display("FAIL %s rdy=%b vld=%b col=%h x=%0d y=%0d busy=%b cmp=%b want all 0", tag,
               o_in_ready, o_out_valid, o_out_col, o_out_x, o_out_y, o_busy, o_complete);
      bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i_in_valid = 1'b1; i_start = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset_hold");
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("idle_no_accept");
    // start and reset together: reset wins
    rst = 1'b1; i_start = 1'b1;
    @(negedge clk);
    rst = 1'b0; i_start = 1'b0; i_in_valid = 1'b0;
    @(negedge clk);
    check_idle_outputs("start_with_reset");
  endtask

  task automatic test_basic_frame();
    fill_image(1);
    run_frame(0, 1, -1);
    total++;
    if (o_complete !== 1'b1 || o_busy !== 1'b0) begin
      $display("FAIL done_state complete=%b busy=%b want 1/0", o_complete, o_busy);
      bad++;
    end
  endtask

  task automatic test_backpressure();
    fill_image(1);
    run_frame(2, 1, -1);
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      fill_image(0);
      run_frame(1, 0, -1);
    end
  endtask

  task automatic test_reset_mid_frame();
    fill_image(0);
    run_frame(0, 0, 2 * W + 3);
    @(negedge clk);
    rst = 1'b1; i_in_valid = 1'b0; i_start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("mid_frame_reset");
    fill_image(1);
    run_frame(0, 1, -1);
  endtask

  task automatic test_start_while_busy();
    fill_image(0);
    run_frame(3, 0, -1);
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_random();
    test_reset_mid_frame();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rb_window_stream.md
# rb_window_stream

Parametrised reuse-buffer block that turns a raster pixel stream into K-pixel vertical window columns using K-1 BRAM line banks with rotating row steering. It replaces the fixed-size, unhandshaked line-buffer path between the external pixel source and the neighbourhood-processing datapath. It adds valid/ready flow control, a frame FSM with a start/complete pair, and coordinate tags on every output column.

## Interface
- PIXEL_WIDTH, 8, bits per pixel
- K, 3, window height; legal range 2..8
- IMG_W, 64, pixels per row; must be at least 2
- IMG_H, 64, rows per frame; must be at least K
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begins a frame from IDLE or DONE; ignored in RUN and DRAIN
- in_valid  in  1  in_pixel holds a valid pixel
- in_ready  out  1  block accepts a pixel this cycle
- in_pixel  in  PIXEL_WIDTH  raster-order pixel
- out_valid  out  1  out_col is valid
- out_ready  in  1  consumer takes out_col this cycle
- out_col  out  K*PIXEL_WIDTH  window column; top slice is the newest row
- out_x  out  clog2(IMG_W)  column index of the output column
- out_y  out  clog2(IMG_H)  row index of the newest pixel in the column
- busy  out  1  high in RUN and DRAIN
- complete  out  1  level, high in DONE

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE or DONE, start=1 → RUN. x, y and ptr are cleared to 0, and complete falls.
  - RUN, acceptance of the pixel at (IMG_W-1, IMG_H-1) → DRAIN.
  - DRAIN, output register empty or taken → DONE.
- A pixel is accepted when in_valid && in_ready.
  - in_ready = (state==RUN) && (!out_valid || out_ready). It is combinational.
- x and y are raster counters. x wraps at IMG_W-1 and increments y.
- ptr runs 0..K-2 and names the bank holding the oldest stored row. It increments mod (K-1) when x wraps.
- For each accepted pixel at (x, y):
  - Read address x in all K-1 banks.
  - Write in_pixel to bank ptr at address x. Banks are read-first: the old value is returned the same cycle.
  - Steering: slot j (j=0 oldest … K-2 newest) takes bank (ptr+j) mod (K-1).
  - Column layout: out_col = {in_pixel, slot K-2, …, slot 0}.
- Priming: pixels with y < K-1 fill the banks and produce no output. From y = K-1 onward, every accepted pixel produces exactly one output column.
- Outputs per frame: IMG_W*(IMG_H-K+1).
- Line bank contents are never cleared. Priming overwrites every read location before it is used.
- K=2: one bank, ptr is constantly 0, and steering is identity.

## Timing
- Reset values: in_ready 0, out_valid 0, out_col 0, out_x 0, out_y 0, busy 0, complete 0, state IDLE, ptr 0.
- Latency: a pixel accepted at edge t appears on out_col/out_valid after edge t+1 (one cycle; synchronous BRAM read plus output register).
- in_pixel is delayed one stage to align with the read data.
- Throughput is 1 pixel/cycle with out_ready held high.
- Backpressure:
  - While out_valid && !out_ready, out_col, out_x and out_y stay stable and in_ready is 0.
  - No pixel is dropped or duplicated.
- In DRAIN, in_ready is 0. complete rises on the cycle after the final output handshake, or after the final pixel if no output is pending.
- rst mid-frame:
  - Returns to IDLE on the next edge with the reset values above.
  - A pending output is discarded.
  - A following start reproduces a clean frame.
- start while busy has no effect.
- start and rst in the same cycle: rst wins.

## Structure
- Shared package `rb_pkg` holds:
  - the state enum;
  - a clog2-based width function;
  - slot-index helper constants.
- Sub-module `rb_line_mem`: a K-1 bank, IMG_W-deep, read-first simple dual-port memory with one write bank select and a common read address. This keeps it inferable as BRAM.
- Steering mux, counters, FSM and output register live in the top module.

## Test plan
- Reset: assert rst for 2 cycles → all outputs read 0 and state is IDLE; in_valid=1 is not accepted.
- Basic frame (K=3, IMG_W=4, IMG_H=4, pixel=y*16+x, out_ready=1, in_valid=1):
  - First out_valid comes 1 cycle after the 9th acceptance: out_col={0x20,0x10,0x00}, out_x=0, out_y=2.
  - Exactly 8 outputs; complete rises after the last one.
- Rotation (K=3, IMG_W=4, IMG_H=6) → at out_x=2, out_y=5, out_col={0x52,0x42,0x32}. Confirms ptr wrap.
- Backpressure: drop out_ready for 3 cycles at column (1,3) → out_col holds {0x31,0x21,0x11} and in_ready stays 0. The output sequence is identical to the unstalled run.
- Random in_valid gaps and random out_ready → the output sequence matches the golden model bit for bit.
- rst pulse at pixel (2,2), then start → the full frame matches a clean run. A start issued during RUN changes nothing.
